// File: rtl/blinky_arbiter.sv
// blinky_arbiter
// Shares one status LED between num_req requesters. Each requester asks to
// flash a blink code (1-15 pulses). A round-robin arbiter grants one requester
// at a time, and a sequencer FSM then plays the pulse train plus an
// inter-code gap before pulsing done back to that requester.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset (aborts any sequence, no done)
//   req_i    - per-requester request level
//   code_i   - 4-bit blink count per requester, requester i at [4i+3:4i]
//   gnt_o    - one-hot grant, zero when idle (registered)
//   done_o   - one-cycle completion pulse to the granted requester (registered)
//   busy_o   - high whenever the sequencer is not idle (registered)
//   blinky_o - LED drive, active high (registered)
module blinky_arbiter #(
  parameter int clk_freq_hz = 50_000,
  parameter int unit_hz     = 10,
  parameter int gap_units   = 4,
  parameter int num_req     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [num_req-1:0]   req_i,
  input  logic [4*num_req-1:0] code_i,
  output logic [num_req-1:0]   gnt_o,
  output logic [num_req-1:0]   done_o,
  output logic                 busy_o,
  output logic                 blinky_o
);

  // One blink unit in clock cycles (must be >= 2).
  localparam int unit_cyc = clk_freq_hz / unit_hz;
  localparam int tw       = $clog2(unit_cyc);
  localparam int iw       = $clog2(num_req);
  localparam int gw       = $clog2(gap_units + 1);

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_on   = 3'd1,
    st_off  = 3'd2,
    st_gap  = 3'd3,
    st_done = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [iw-1:0]    winner_r, winner_s;
  logic [iw-1:0]    ptr_r, ptr_s;
  logic [3:0]       pulses_r, pulses_s;
  logic [tw-1:0]    timer_r, timer_s;
  logic [gw-1:0]    gap_r, gap_s;

  logic [iw-1:0]    pick_s;
  logic [iw-1:0]    cand_s;
  logic             hit_s;
  logic [3:0]       pick_code_s;
  logic             unit_end_s;

  logic [num_req-1:0] gnt_s, done_s;
  logic               busy_s, blinky_s;
  logic [num_req-1:0] gnt_r, done_r;
  logic               busy_r, blinky_r;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    pick_s = ptr_r;
    cand_s = ptr_r;
    hit_s  = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      cand_s = iw'((int'(ptr_r) + i) % num_req);
      pick_s = (!hit_s && req_i[cand_s]) ? cand_s : pick_s;
      hit_s  = hit_s | req_i[cand_s];
    end
  end

  assign pick_code_s = code_i[{pick_s, 2'b00} +: 4];
  assign unit_end_s  = (timer_r == tw'(unit_cyc - 1));

  // Next-state logic for the sequencer and its counters.
  always_comb begin
    state_s  = state_r;
    winner_s = winner_r;
    ptr_s    = ptr_r;
    pulses_s = pulses_r;
    timer_s  = timer_r;
    gap_s    = gap_r;
    case (state_r)
      st_idle: begin
        timer_s = {tw{1'b0}};
        if (hit_s) begin
          winner_s = pick_s;
          pulses_s = pick_code_s;
          state_s  = (pick_code_s == 4'd0) ? st_done : st_on;
        end else begin
          state_s = st_idle;
        end
      end
      st_on: begin
        if (unit_end_s) begin
          timer_s  = {tw{1'b0}};
          pulses_s = pulses_r - 4'd1;
          // pulses_r still counts the pulse just finished.
          if (pulses_r > 4'd1) begin
            state_s = st_off;
          end else begin
            state_s = st_gap;
            gap_s   = {gw{1'b0}};
          end
        end else begin
          timer_s = timer_r + tw'(1);
        end
      end
      st_off: begin
        if (unit_end_s) begin
          timer_s = {tw{1'b0}};
          state_s = st_on;
        end else begin
          timer_s = timer_r + tw'(1);
        end
      end
      st_gap: begin
        if (unit_end_s) begin
          timer_s = {tw{1'b0}};
          if (gap_r == gw'(gap_units - 1)) begin
            state_s = st_done;
          end else begin
            gap_s = gap_r + gw'(1);
          end
        end else begin
          timer_s = timer_r + tw'(1);
        end
      end
      st_done: begin
        timer_s = {tw{1'b0}};
        state_s = st_idle;
        if (winner_r == iw'(num_req - 1)) begin
          ptr_s = {iw{1'b0}};
        end else begin
          ptr_s = winner_r + iw'(1);
        end
      end
      default: begin
        state_s = st_idle;
        timer_s = {tw{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    gnt_s    = {num_req{1'b0}};
    done_s   = {num_req{1'b0}};
    busy_s   = (state_s != st_idle);
    blinky_s = (state_s == st_on);
    if (state_s != st_idle) begin
      gnt_s = {{(num_req-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      gnt_s = {num_req{1'b0}};
    end
    if (state_s == st_done) begin
      done_s = {{(num_req-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      done_s = {num_req{1'b0}};
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= st_idle;
      winner_r <= {iw{1'b0}};
      ptr_r    <= {iw{1'b0}};
      pulses_r <= 4'd0;
      timer_r  <= {tw{1'b0}};
      gap_r    <= {gw{1'b0}};
      gnt_r    <= {num_req{1'b0}};
      done_r   <= {num_req{1'b0}};
      busy_r   <= 1'b0;
      blinky_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      winner_r <= winner_s;
      ptr_r    <= ptr_s;
      pulses_r <= pulses_s;
      timer_r  <= timer_s;
      gap_r    <= gap_s;
      gnt_r    <= gnt_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      blinky_r <= blinky_s;
    end
  end

  assign gnt_o    = gnt_r;
  assign done_o   = done_r;
  assign busy_o   = busy_r;
  assign blinky_o = blinky_r;

endmodule

// File: tb/tb_blinky_arbiter.sv
// Directed bench for blinky_arbiter with a done-event scoreboard.
// Unit shortened to 5 cycles so long codes stay within a small cycle budget.
module tb_blinky_arbiter;

  localparam int U      = 5;
  localparam int GAP    = 4;
  localparam int NREQ   = 4;
  localparam int PERIOD = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_i;
  logic [4*NREQ-1:0] code_i;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   done_o;
  logic              busy_o;
  logic              blinky_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  blinky_arbiter #(
    .clk_freq_hz(50_000),
    .unit_hz    (10_000),
    .gap_units  (GAP),
    .num_req    (NREQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .code_i  (code_i),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .blinky_o(blinky_o)
  );

  always #(PERIOD/2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic int seq_len(input int code);
    return (2 * code - 1 + GAP) * U;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
    if (cyc > target) check("schedule", cyc, target);
  endtask

  task automatic push_exp(input int idx, input int at);
    exp_t e;
    e.idx = idx;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Walk a whole pulse train from grant cycle g; optionally drop a request mid-way.
  task automatic check_wave(input int idx, input int code, input int g, input int drop_at);
    int   len;
    int   bad_b;
    int   bad_g;
    logic exp_b;
    len   = seq_len(code);
    bad_b = 0;
    bad_g = 0;
    wait_cycle(g);
    for (int t = 0; t < len; t++) begin
      if (g + t == drop_at) req_i[idx] = 1'b0;
      exp_b = (((t / U) % 2) == 0) && ((t / U) < (2 * code - 1));
      if (blinky_o !== exp_b) bad_b++;
      if (gnt_o !== oh(idx) || busy_o !== 1'b1 || done_o !== '0) bad_g++;
      if (t != len - 1) @(negedge clk);
    end
    check("wave_blinky", bad_b, 0);
    check("wave_gnt", bad_g, 0);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("done_missing_cyc", cyc, e.cyc);
    end
    if (done_o !== '0) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", done_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_idx", done_o, oh(e.idx));
        check("done_cycle", cyc, e.cyc);
        check("done_gnt", gnt_o, oh(e.idx));
      end
    end
  end

  initial begin
    int  g;
    int  g2;
    int  d;
    time t_rise;

    rst    = 1'b1;
    req_i  = '0;
    code_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {gnt_o, done_o, busy_o, blinky_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request, code 3 on requester 0.
    code_i = 16'h0003;
    req_i  = 4'b0001;
    g = cyc + 1;
    push_exp(0, g + seq_len(3));
    wait_cycle(g);
    t_rise = $time;
    check("t1_first_rise", {gnt_o, busy_o, blinky_o}, {4'b0001, 1'b1, 1'b1});
    check_wave(0, 3, g, -1);
    d = g + seq_len(3);
    wait_cycle(d);
    check("t1_done_time", 32'($time - t_rise), 45 * PERIOD);
    req_i = '0;
    wait_cycle(d + 2);
    check("t1_idle_after", {gnt_o, busy_o, blinky_o}, 0);

    // Contention: reset ptr, then requesters 0 and 1 held with codes 1 and 2.
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    code_i = 16'h0021;
    req_i  = 4'b0011;
    g = cyc + 1;
    push_exp(0, g + seq_len(1));
    check_wave(0, 1, g, -1);
    g = g + seq_len(1) + 2;
    push_exp(1, g + seq_len(2));
    check_wave(1, 2, g, -1);
    g = g + seq_len(2) + 2;
    push_exp(0, g + seq_len(1));
    check_wave(0, 1, g, -1);
    g = g + seq_len(1) + 2;
    push_exp(1, g + seq_len(2));
    check_wave(1, 2, g, -1);
    wait_cycle(g + seq_len(2));
    req_i = '0;

    // Simultaneous new requests 2 and 0 with ptr at 2.
    wait_cycle(cyc + 3);
    code_i = 16'h0101;
    req_i  = 4'b0101;
    g = cyc + 1;
    push_exp(2, g + seq_len(1));
    check_wave(2, 1, g, -1);
    wait_cycle(g + seq_len(1));
    req_i[2] = 1'b0;
    g2 = g + seq_len(1) + 2;
    push_exp(0, g2 + seq_len(1));
    check_wave(0, 1, g2, -1);
    wait_cycle(g2 + seq_len(1));
    req_i[0] = 1'b0;

    // Code 0 on requester 3.
    wait_cycle(cyc + 3);
    code_i = 16'h0000;
    req_i  = 4'b1000;
    g = cyc + 1;
    push_exp(3, g);
    wait_cycle(g);
    check("t4_code0", {gnt_o, done_o, busy_o, blinky_o}, {4'b1000, 4'b1000, 1'b1, 1'b0});
    req_i = '0;
    wait_cycle(g + 1);
    check("t4_idle", {gnt_o, busy_o, blinky_o}, 0);

    // Move ptr to 2 with a code-0 grant on requester 1.
    wait_cycle(cyc + 2);
    req_i = 4'b0010;
    g = cyc + 1;
    push_exp(1, g);
    wait_cycle(g);
    req_i = '0;

    // Abort mid second pulse of a code-5 sequence on requester 2.
    wait_cycle(cyc + 3);
    code_i = 16'h0500;
    req_i  = 4'b0100;
    g = cyc + 1;
    wait_cycle(g + 2 * U + 2);
    check("t5_mid_pulse", {gnt_o, blinky_o}, {4'b0100, 1'b1});
    rst   = 1'b1;
    req_i = '0;
    @(negedge clk);
    check("t5_abort_outputs", {gnt_o, done_o, busy_o, blinky_o}, 0);
    rst = 1'b0;
    wait_cycle(cyc + 2 * U);
    check("t5_stay_idle", {gnt_o, busy_o, blinky_o}, 0);
    // ptr must be back at 0: requester 0 wins over 3.
    code_i = 16'h0001;
    req_i  = 4'b1001;
    g = cyc + 1;
    push_exp(0, g + seq_len(1));
    check_wave(0, 1, g, -1);
    wait_cycle(g + seq_len(1));
    req_i[0] = 1'b0;
    g2 = g + seq_len(1) + 2;
    push_exp(3, g2);
    wait_cycle(g2);
    check("t5_then_3", gnt_o, 4'b1000);
    req_i[3] = 1'b0;

    // Dropped request: requester 1, code 15, released after first pulse.
    wait_cycle(cyc + 3);
    code_i = 16'h00F0;
    req_i  = 4'b0010;
    g = cyc + 1;
    push_exp(1, g + seq_len(15));
    check_wave(1, 15, g, g + U);
    wait_cycle(g + seq_len(15) + 3);
    check("t6_idle_after", {gnt_o, busy_o, blinky_o}, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
